// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath width and float32 total-order key
package cnn_pkg;
    localparam int DATA_WIDTH = 32;
    function automatic logic [DATA_WIDTH-1:0] f32_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : {1'b1, x[DATA_WIDTH-2:0]};
    endfunction
endpackage

// File: rtl/cnn_fmax2.sv
// cnn_fmax2: combinational 2-input float32 max under total order, winner passed bit-exact
module cnn_fmax2
    import cnn_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    assign y = (f32_key(a) >= f32_key(b)) ? a : b;
endmodule

// File: rtl/cnn_maxp_3x3_stream.sv
// cnn_maxp_3x3_stream: streaming 3x3 stride-2 pad-1 float32 max-pool over back-to-back raster channel frames
module cnn_maxp_3x3_stream #(
    parameter int DATA_WIDTH   = cnn_pkg::DATA_WIDTH,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out
);
    import cnn_pkg::*;
    localparam int cw = $clog2(IMAGE_WIDTH);
    localparam int rw = $clog2(IMAGE_HEIGHT);
    // all-ones has order key 0: it loses every compare and only ties with itself
    localparam logic [DATA_WIDTH-1:0] pad = '1;
    logic [cw-1:0] col;
    logic [rw-1:0] row;
    logic [DATA_WIDTH-1:0] lb_a [IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0] lb_b [IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0] w1 [3];
    logic [DATA_WIDTH-1:0] w2 [3];
    logic [DATA_WIDTH-1:0] cand [9];
    logic [DATA_WIDTH-1:0] t [8];
    logic en, top, left, fire, col_end;
    assign en      = reset & valid_in;
    assign top     = row == rw'(1);
    assign left    = col == cw'(1);
    assign col_end = col == cw'(IMAGE_WIDTH - 1);
    assign fire    = en & row[0] & col[0];
    always_ff @(posedge clk) begin
        if (!reset) begin
            row       <= '0;
            col       <= '0;
            valid_out <= 1'b0;
            pxl_out   <= '0;
        end else begin
            valid_out <= fire;
            if (fire) pxl_out <= t[7];
            if (valid_in) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) row <= (row == rw'(IMAGE_HEIGHT - 1)) ? '0 : row + 1'b1;
            end
        end
    end
    // lb_a holds the previous row, lb_b the one before; w1/w2 are the two prior columns
    always_ff @(posedge clk) begin
        if (en) begin
            lb_a[col] <= pxl_in;
            lb_b[col] <= lb_a[col];
            w1        <= '{lb_b[col], lb_a[col], pxl_in};
            w2        <= w1;
        end
    end
    always_comb begin
        cand[0] = (top | left) ? pad : w2[0];
        cand[1] = top ? pad : w1[0];
        cand[2] = top ? pad : lb_b[col];
        cand[3] = left ? pad : w2[1];
        cand[4] = w1[1];
        cand[5] = lb_a[col];
        cand[6] = left ? pad : w2[2];
        cand[7] = w1[2];
        cand[8] = pxl_in;
    end
    for (genvar i = 0; i < 8; i++) begin : g_tree
        if (i < 4) begin : g_leaf
            cnn_fmax2 u_max (.a(cand[2*i]), .b(cand[2*i+1]), .y(t[i]));
        end else if (i == 4) begin : g_odd
            cnn_fmax2 u_max (.a(cand[8]), .b(t[0]), .y(t[i]));
        end else begin : g_node
            cnn_fmax2 u_max (.a(t[2*i-9]), .b(t[2*i-8]), .y(t[i]));
        end
    end
endmodule

// File: tb/tb_cnn_maxp_3x3_stream.sv
// tb_cnn_maxp_3x3_stream: directed and randomized frames checked against a whole-frame pooling model
module tb_cnn_maxp_3x3_stream;
    localparam int W = 16;
    localparam int H = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic valid_in = 1'b0;
    logic [31:0] pxl_in = '0;
    logic [31:0] pxl_out;
    logic valid_out;
    int n_assert = 0;
    int n_fail = 0;
    int pr = 0;
    int pc = 0;
    logic [31:0] img [H][W];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    cnn_maxp_3x3_stream #(.DATA_WIDTH(32), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out), .valid_out(valid_out)
    );

    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? ~x : x ^ 32'h8000_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_frame();
        for (int r = 0; r < H; r += 2)
            for (int c = 0; c < W; c += 2) begin
                logic [31:0] best;
                bit found;
                best = '0;
                found = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (r + dr >= 0 && c + dc >= 0) begin
                            logic [31:0] v;
                            v = img[r+dr][c+dc];
                            if (!found || okey(v) > okey(best)) best = v;
                            found = 1;
                        end
                exp_q.push_back(best);
            end
    endtask

    task automatic step(input logic v, input logic [31:0] p);
        logic ev;
        ev = v && (pr % 2 == 1) && (pc % 2 == 1);
        valid_in = v;
        pxl_in = p;
        @(posedge clk);
        #1;
        check("valid_out", {31'b0, valid_out}, {31'b0, ev});
        if (ev) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL exp_queue: observed empty expected entry");
            end
            if (exp_q.size() > 0) check("pxl_out", pxl_out, exp_q.pop_front());
        end
        if (v) begin
            pc++;
            if (pc == W) begin
                pc = 0;
                pr = (pr == H - 1) ? 0 : pr + 1;
            end
        end
    endtask

    task automatic run_frame(input int mode, input int gap_pct, input int max_pix);
        int sr, sc;
        sr = int'($urandom_range(H - 1));
        sc = int'($urandom_range(W - 1));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0: img[r][c] = 32'(r * 16 + c);
                    1: img[r][c] = (r == sr && c == sc) ? 32'hC000_0000 : 32'hBF80_0000;
                    2: img[r][c] = ($urandom_range(1) == 1) ? 32'hBF00_0000 : 32'h3E80_0000;
                    3: img[r][c] = 32'h7F00_0000;
                    4: img[r][c] = (r == 0) ? 32'h4000_0000 : 32'h3F80_0000;
                    default: img[r][c] = $urandom;
                endcase
        model_frame();
        for (int i = 0; i < max_pix; i++) begin
            while (int'($urandom_range(99)) < gap_pct) step(1'b0, $urandom);
            step(1'b1, img[i / W][i % W]);
        end
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 1'b1;
        pxl_in = 32'h7F7F_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pxl_out", pxl_out, 32'h0);
        check("reset_valid_out", {31'b0, valid_out}, 32'h0);
        reset = 1'b1;
        valid_in = 1'b0;
        run_frame(0, 0, W * H);
        run_frame(1, 0, W * H);
        run_frame(2, 0, W * H);
        run_frame(3, 0, W * H);
        run_frame(4, 0, W * H);
        for (int k = 0; k < 4; k++) run_frame(5, 0, W * H);
        run_frame(0, 30, W * H);
        run_frame(5, 30, W * H);
        run_frame(0, 0, 5 * W + 3);
        reset = 1'b0;
        valid_in = 1'b1;
        pxl_in = 32'h7F00_0000;
        @(posedge clk);
        #1;
        check("midreset_pxl_out", pxl_out, 32'h0);
        check("midreset_valid_out", {31'b0, valid_out}, 32'h0);
        reset = 1'b1;
        valid_in = 1'b0;
        exp_q.delete();
        pr = 0;
        pc = 0;
        run_frame(0, 0, W * H);
        check("leftover_outputs", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
